result_ascii_tx: RTL and testbench
==================================

Name: result_ascii_tx

Overview:
- Output-side counterpart to the calculator's token-parsing datapath. The input side turns ASCII digits and operators into operands; this block turns the final signed binary result back into an ASCII character stream.
- On start it latches the result and converts it to decimal with a sequential divide-by-10.
- It then transmits, most significant first: an optional '-', the decimal digits, and the terminator '#'.
- Characters leave one at a time over a valid/ready handshake to the display or UART front end.

Parameters:
- WIDTH, 16, result width in bits; two's-complement signed.
- DIGITS, 5, digit buffer depth; must be at least ceil(WIDTH*log10(2)).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request to transmit result; honoured only in IDLE.
- result  in  WIDTH  signed value; sampled only in the cycle start is accepted.
- busy  out  1  high from the cycle after start is accepted until done.
- char_out  out  8  ASCII character.
- char_valid  out  1  char_out holds a valid character.
- char_ready  in  1  sink accepts char_out when char_valid && char_ready.
- done  out  1  one-cycle pulse after '#' is accepted.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Forces state IDLE.
  - Outputs: busy=0, char_valid=0, done=0, char_out=8'h00.
  - Digit count, negative flag and buffer pointer cleared.
  - Applies mid-operation too: any partial stream is abandoned and no further characters are issued.
- States: IDLE, DIV, STORE, SIGN, EMIT, TERM, FIN.
- IDLE:
  - On start=1: latch neg = result[WIDTH-1].
  - Latch magnitude = neg ? -result : result, as a WIDTH-bit unsigned value. The most-negative input yields 2^(WIDTH-1) correctly.
  - Clear digit count and go to DIV.
- DIV: restoring shift-subtract division of magnitude by 10.
  - Exactly WIDTH cycles.
  - Produces quotient (WIDTH bits) and remainder (4 bits, range 0..9).
- STORE (1 cycle):
  - Push the remainder into the digit buffer at index count; count++.
  - Set magnitude = quotient.
  - If quotient != 0, go to DIV; otherwise go to SIGN if neg, else EMIT.
  - Value 0 therefore stores exactly one digit, '0'. No leading zeros are ever produced.
- Conversion latency: n_digits*(WIDTH+1) cycles from start acceptance to the first char_valid.
- SIGN: present 8'h2D ('-'), then go to EMIT on handshake.
- EMIT:
  - Present 8'h30 + buffer[count-1], i.e. LIFO order, so the most significant digit goes first.
  - On handshake, count--.
  - When the last digit is accepted, go to TERM.
- TERM: present 8'h23 ('#'); on handshake go to FIN.
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE. A new start is accepted in the cycle after FIN.
- Handshake rules:
  - char_valid is registered and asserted in SIGN, EMIT and TERM.
  - Once asserted, char_valid and char_out stay stable until accepted.
  - The next character appears in the cycle after acceptance. Maximum throughput is one character per clock (back-to-back valid while ready=1).
  - char_valid is never asserted while the block is converting.
- start while busy: ignored. result is not re-sampled and the stream is unaffected.
- char_ready during IDLE, DIV or STORE: ignored.
- Simultaneous rst and start: rst wins.
- Stream length is 1+n_digits+neg characters, i.e. at most DIGITS+2.

Test Plan:
- WIDTH=16, result=0, char_ready=1 -> stream 8'h30, 8'h23. done pulses once; busy low afterwards. First valid 17 cycles after start.
- result=12345, char_ready=1 -> "12345#" (31 32 33 34 35 23) on consecutive cycles. First valid 85 cycles after start.
- result=-7 (16'hFFF9) -> "-7#"; result=-32768 (16'h8000) -> "-32768#". Covers most-negative magnitude.
- result=905 with char_ready held low for 3 cycles while '9' is valid, then toggling 1/0 -> char_out stays 8'h39 while stalled. Each character is transferred exactly once; the stream is "905#".
- result=-42 with a second start (result=11) pulsed mid-conversion -> stream is still "-42#". A start one cycle after done then produces "11#".
- result=678, rst asserted while '7' is valid -> next cycle char_valid=0, busy=0, done=0, state IDLE. No '8' or '#' is emitted; a fresh start afterwards works normally.

Source files
------------

// File: rtl/result_ascii_tx.sv
// Signed result to ASCII stream: optional '-', decimal digits MSD first, '#'.
// Sequential divide-by-10 conversion, one character per valid/ready handshake.
module result_ascii_tx #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [7:0]       char_out,
  output logic             char_valid,
  input  logic             char_ready,
  output logic             done
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE, DIV, STORE, SIGN, EMIT, TERM, FIN
  } state_t;

  state_t           state;
  logic             neg;
  logic [WIDTH-1:0] quo;
  logic [3:0]       rem;
  logic [BW-1:0]    bcnt;
  logic [CW-1:0]    count;
  logic [3:0]       dbuf [DIGITS];

  logic [4:0]       trial;
  logic [4:0]       diff;
  logic             ge10;
  logic [3:0]       top_dig;
  logic [3:0]       next_dig;
  logic             xfer;

  always_comb begin
    trial    = {rem, quo[WIDTH-1]};
    diff     = trial - 5'd10;
    ge10     = (trial >= 5'd10);
    top_dig  = dbuf[count - 1'b1];
    next_dig = dbuf[count - CW'(2)];
    xfer     = char_valid && char_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      neg        <= 1'b0;
      quo        <= '0;
      rem        <= '0;
      bcnt       <= '0;
      count      <= '0;
      busy       <= 1'b0;
      char_out   <= 8'h00;
      char_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            neg   <= result[WIDTH-1];
            // two's-complement negate also maps the most-negative value correctly
            quo   <= result[WIDTH-1] ? -result : result;
            rem   <= '0;
            bcnt  <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= DIV;
          end
        end
        DIV: begin
          quo  <= {quo[WIDTH-2:0], ge10};
          rem  <= ge10 ? diff[3:0] : trial[3:0];
          bcnt <= bcnt + 1'b1;
          if (bcnt == BW'(WIDTH - 1)) state <= STORE;
        end
        STORE: begin
          dbuf[count] <= rem;
          count       <= count + 1'b1;
          rem         <= '0;
          bcnt        <= '0;
          if (quo != '0) begin
            state <= DIV;
          end else if (neg) begin
            state      <= SIGN;
            char_out   <= 8'h2D;
            char_valid <= 1'b1;
          end else begin
            // the digit stored this cycle is the most significant one
            state      <= EMIT;
            char_out   <= 8'h30 + {4'h0, rem};
            char_valid <= 1'b1;
          end
        end
        SIGN: begin
          if (xfer) begin
            state    <= EMIT;
            char_out <= 8'h30 + {4'h0, top_dig};
          end
        end
        EMIT: begin
          if (xfer) begin
            count <= count - 1'b1;
            if (count == CW'(1)) begin
              state    <= TERM;
              char_out <= 8'h23;
            end else begin
              char_out <= 8'h30 + {4'h0, next_dig};
            end
          end
        end
        TERM: begin
          if (xfer) begin
            state      <= FIN;
            char_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_ascii_tx.sv
// Directed bench for result_ascii_tx: stream contents, latency,
// back-pressure, start-while-busy and mid-stream reset.
module tb_result_ascii_tx;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] result;
  logic        busy;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_ready;
  logic        done;

  int errors;
  int checks;

  result_ascii_tx #(.WIDTH(16), .DIGITS(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .result     (result),
    .busy       (busy),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one transaction and records what the sink saw.
  // mode 0: ready=1; 1: 3 stall cycles then toggle;
  // mode 2: extra start(11) mid-conversion; 3: reset while '7' valid.
  task automatic run(input logic [15:0] val, input int mode,
                     output logic [63:0] str, output int n,
                     output int first, output int ndone,
                     output int span, output int stab_err,
                     output int stalls, output bit tmo);
    int cyc, t0, t1, tog;
    logic pv, pr, r;
    logic [7:0] pc;
    bit fin;
    str = '0; n = 0; first = -1; ndone = 0; span = 0;
    stab_err = 0; stalls = 0; tmo = 0;
    t0 = -1; t1 = -1; tog = 0; pv = 0; pr = 0; pc = 0; fin = 0; cyc = 0;
    start = 1'b1;
    result = val;
    char_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    while (!fin && cyc < 400) begin
      if (pv && !pr && (char_valid !== 1'b1 || char_out !== pc)) stab_err++;
      if (char_valid && first < 0) first = cyc;
      if (done) begin
        ndone++;
        fin = 1;
      end
      if (mode == 2 && cyc == 5) begin
        start = 1'b1;
        result = 16'd11;
      end else begin
        start = 1'b0;
      end
      r = 1'b1;
      if (mode == 1 && char_valid) begin
        if (stalls < 3) begin
          r = 1'b0;
          stalls++;
        end else begin
          r = (tog % 2 == 0);
          tog++;
        end
      end
      if (mode == 3 && char_valid && char_out == 8'h37) begin
        rst = 1'b1;
        r = 1'b0;
        fin = 1;
      end
      char_ready = r;
      if (char_valid && r) begin
        str = {str[55:0], char_out};
        n++;
        if (t0 < 0) t0 = cyc;
        t1 = cyc;
      end
      pv = char_valid;
      pr = r;
      pc = char_out;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    char_ready = 1'b0;
    if (!fin) tmo = 1;
    span = t1 - t0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    result = '0;
    char_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (char_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", char_valid);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b want 0", done);
    end
    checks++;
    if (char_out !== 8'h00) begin
      errors++; $display("FAIL reset_char: got %h want 00", char_out);
    end
  endtask

  task automatic test_zero();
    logic [63:0] s; int n, f, nd, sp, se, st; bit tmo;
    run(16'd0, 0, s, n, f, nd, sp, se, st, tmo);
    checks++;
    if (tmo !== 1'b0) begin
      errors++; $display("FAIL zero_timeout: no done within budget");
    end
    checks++;
    if (s !== 64'h3023) begin
      errors++; $display("FAIL zero_stream: got %h want 3023", s);
    end
    checks++;
    if (f !== 17) begin
      errors++; $display("FAIL zero_latency: got %0d want 17", f);
    end
    checks++;
    if (nd !== 1) begin
      errors++; $display("FAIL zero_done_count: got %0d want 1", nd);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL zero_after: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] s; int n, f, nd, sp, se, st; bit tmo;
    run(16'd12345, 0, s, n, f, nd, sp, se, st, tmo);
    checks++;
    if (s !== 64'h313233343523) begin
      errors++; $display("FAIL b2b_stream: got %h want 313233343523", s);
    end
    checks++;
    if (f !== 85) begin
      errors++; $display("FAIL b2b_latency: got %0d want 85", f);
    end
    checks++;
    if (n !== 6 || sp !== 5) begin
      errors++; $display("FAIL b2b_span: got n=%0d span=%0d want 6 5", n, sp);
    end
  endtask

  task automatic test_negative();
    logic [63:0] s; int n, f, nd, sp, se, st; bit tmo;
    run(16'hFFF9, 0, s, n, f, nd, sp, se, st, tmo);
    checks++;
    if (s !== 64'h2D3723) begin
      errors++; $display("FAIL neg7_stream: got %h want 2d3723", s);
    end
    run(16'h8000, 0, s, n, f, nd, sp, se, st, tmo);
    checks++;
    if (s[55:0] !== 56'h2D333237363823 || n !== 7) begin
      errors++; $display("FAIL min_stream: got %h n=%0d want 2d333237363823 7", s, n);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] s; int n, f, nd, sp, se, st; bit tmo;
    run(16'd905, 1, s, n, f, nd, sp, se, st, tmo);
    checks++;
    if (s !== 64'h39303523 || n !== 4) begin
      errors++; $display("FAIL stall_stream: got %h n=%0d want 39303523 4", s, n);
    end
    checks++;
    if (se !== 0) begin
      errors++; $display("FAIL stall_stable: got %0d changes want 0", se);
    end
    checks++;
    if (st !== 3) begin
      errors++; $display("FAIL stall_cycles: got %0d want 3", st);
    end
  endtask

  task automatic test_start_while_busy();
    logic [63:0] s; int n, f, nd, sp, se, st; bit tmo;
    run(16'hFFD6, 2, s, n, f, nd, sp, se, st, tmo);
    checks++;
    if (s !== 64'h2D343223) begin
      errors++; $display("FAIL busy_start_stream: got %h want 2d343223", s);
    end
    run(16'd11, 0, s, n, f, nd, sp, se, st, tmo);
    checks++;
    if (s !== 64'h313123) begin
      errors++; $display("FAIL restart_stream: got %h want 313123", s);
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] s; int n, f, nd, sp, se, st; bit tmo;
    int nvalid, ndone;
    run(16'd678, 3, s, n, f, nd, sp, se, st, tmo);
    rst = 1'b0;
    checks++;
    if (char_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: valid=%b busy=%b done=%b want 0 0 0",
               char_valid, busy, done);
    end
    checks++;
    if (s !== 64'h36) begin
      errors++; $display("FAIL midrst_partial: got %h want 36", s);
    end
    nvalid = 0;
    ndone = 0;
    char_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (char_valid) nvalid++;
      if (done) ndone++;
      @(posedge clk); #1;
    end
    char_ready = 1'b0;
    checks++;
    if (nvalid !== 0 || ndone !== 0) begin
      errors++; $display("FAIL midrst_quiet: valid=%0d done=%0d want 0 0", nvalid, ndone);
    end
    run(16'd678, 0, s, n, f, nd, sp, se, st, tmo);
    checks++;
    if (s !== 64'h36373823) begin
      errors++; $display("FAIL midrst_fresh: got %h want 36373823", s);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    start = 1'b0;
    result = '0;
    char_ready = 1'b0;
    test_reset();
    test_zero();
    test_back_to_back();
    test_negative();
    test_backpressure();
    test_start_while_busy();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
